// File: rtl/vnu_serial_if.sv
// rtl/vnu_serial_if.sv - input/output handshake bundle of the serial variable-node unit
interface vnu_serial_if #(
    parameter int DATA_W = 8,
    parameter int DEG_W  = 4,
    parameter int Q_W    = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic [DATA_W-1:0] in_data;
    logic [DEG_W-1:0]  in_deg;
    logic              out_valid;
    logic              out_ready;
    logic [Q_W-1:0]    out_q;
    logic              out_last;
    logic              dec;
    logic              dec_valid;
    logic              err;

    modport master (
        output in_valid, in_first, in_data, in_deg, out_ready,
        input  in_ready, out_valid, out_q, out_last, dec, dec_valid, err
    );

    modport slave (
        input  in_valid, in_first, in_data, in_deg, out_ready,
        output in_ready, out_valid, out_q, out_last, dec, dec_valid, err
    );
endinterface

// File: rtl/vnu_serial.sv
// rtl/vnu_serial.sv - serial LDPC variable-node unit: accumulate, decide, replay extrinsic messages
module vnu_serial #(
    parameter int DATA_W  = 8,
    parameter int D_MAX   = 12,
    parameter int EXT_W   = 4,
    parameter int SAT_OUT = 1,
    parameter int DEG_W   = 4
) (
    input logic        clk,
    input logic        rst,
    vnu_serial_if.slave bus
);
    localparam int SUM_W = DATA_W + EXT_W;
    localparam int Q_W   = (SAT_OUT != 0) ? DATA_W : SUM_W;
    localparam logic signed [SUM_W-1:0] Q_MAX   = SUM_W'((1 << (DATA_W - 1)) - 1);
    localparam logic [DEG_W-1:0]        DEG_MAX = DEG_W'(D_MAX);
    localparam logic [DEG_W-1:0]        DEG_ONE = DEG_W'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t                  state;
    logic signed [SUM_W-1:0] acc;
    logic [DEG_W-1:0]        deg;
    logic [DEG_W-1:0]        cnt;
    logic [DATA_W-1:0]       msg_buf [D_MAX];

    logic signed [SUM_W-1:0] s_next;
    logic [DATA_W-1:0]       first_msg;
    logic [DATA_W-1:0]       adv_msg;
    logic [DEG_W-1:0]        cnt_inc;
    logic                    in_fire;
    logic                    out_fire;
    logic                    last_msg;

    function automatic logic signed [SUM_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{EXT_W{v[DATA_W-1]}}, v};
    endfunction

    // Symmetric clamp: the most negative DATA_W code never appears on out_q.
    function automatic logic [Q_W-1:0] shape(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] c;
        c = v;
        if (SAT_OUT != 0) begin
            if (v > Q_MAX)
                c = Q_MAX;
            else if (v < -Q_MAX)
                c = -Q_MAX;
        end
        return c[Q_W-1:0];
    endfunction

    // q_0 is formed on the same edge that absorbs the last r, so buf[0] may still be on in_data.
    always_comb begin
        in_fire   = bus.in_valid && bus.in_ready;
        out_fire  = bus.out_valid && bus.out_ready;
        cnt_inc   = cnt + DEG_ONE;
        s_next    = acc + sext(bus.in_data);
        first_msg = (cnt == '0) ? bus.in_data : msg_buf[0];
        adv_msg   = (cnt_inc < DEG_MAX) ? msg_buf[cnt_inc] : msg_buf[0];
        last_msg  = (cnt_inc == deg);
    end

    always_ff @(posedge clk) begin
        if (state == ACCUM && in_fire && !bus.in_first)
            msg_buf[cnt] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            deg           <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_q     <= '0;
            bus.out_last  <= 1'b0;
            bus.dec       <= 1'b0;
            bus.dec_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.dec_valid <= 1'b0;
            bus.err       <= 1'b0;
            case (state)
                IDLE, ACCUM: begin
                    bus.in_ready <= 1'b1;
                    if (in_fire) begin
                        if (bus.in_first) begin
                            acc <= sext(bus.in_data);
                            deg <= bus.in_deg;
                            cnt <= '0;
                            if (bus.in_deg == '0) begin
                                bus.dec       <= bus.in_data[DATA_W-1];
                                bus.dec_valid <= 1'b1;
                                bus.err       <= (state == ACCUM);
                                state         <= IDLE;
                            end else if (bus.in_deg > DEG_MAX) begin
                                bus.err <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                bus.err <= (state == ACCUM);
                                state   <= ACCUM;
                            end
                        end else if (state == IDLE) begin
                            bus.err <= 1'b1;
                        end else begin
                            acc <= s_next;
                            cnt <= cnt_inc;
                            if (last_msg) begin
                                state         <= EMIT;
                                cnt           <= '0;
                                bus.in_ready  <= 1'b0;
                                bus.dec       <= s_next[SUM_W-1];
                                bus.dec_valid <= 1'b1;
                                bus.out_valid <= 1'b1;
                                bus.out_q     <= shape(s_next - sext(first_msg));
                                bus.out_last  <= (deg == DEG_ONE);
                            end
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (bus.out_last) begin
                            state         <= IDLE;
                            bus.in_ready  <= 1'b1;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                        end else begin
                            cnt          <= cnt_inc;
                            bus.out_q    <= shape(acc - sext(adv_msg));
                            bus.out_last <= ((cnt_inc + DEG_ONE) == deg);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vnu_serial.sv
// tb/tb_vnu_serial.sv - randomized bench for vnu_serial against a frame-level model
module tb_vnu_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vnu_serial_if #(.DATA_W(8), .DEG_W(4), .Q_W(8))  bus_s ();
    vnu_serial_if #(.DATA_W(8), .DEG_W(4), .Q_W(12)) bus_w ();

    vnu_serial #(.DATA_W(8), .D_MAX(12), .EXT_W(4), .SAT_OUT(1), .DEG_W(4)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s));
    vnu_serial #(.DATA_W(8), .D_MAX(12), .EXT_W(4), .SAT_OUT(0), .DEG_W(4)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w));

    assign bus_w.in_valid  = bus_s.in_valid;
    assign bus_w.in_first  = bus_s.in_first;
    assign bus_w.in_data   = bus_s.in_data;
    assign bus_w.in_deg    = bus_s.in_deg;
    assign bus_w.out_ready = bus_s.out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int got, input int exp_v);
        n_chk++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp_v, $time);
        end
    endtask

    // Frame-level reference: q_i = (l + sum r) - r_i, clamped when saturating.
    function automatic int mq(input int s, input int r, input bit sat);
        int q;
        q = s - r;
        if (sat && q > 127)  q = 127;
        if (sat && q < -127) q = -127;
        return q;
    endfunction

    int exp_s[$];
    int exp_w[$];
    int seen_s[$];
    int seen_w[$];
    int m_r[$];
    int m_l;
    int m_deg;
    bit m_col    = 1'b0;
    bit exp_rdy  = 1'b0;
    bit exp_dec  = 1'b0;
    bit exp_dv   = 1'b0;
    bit exp_err  = 1'b0;
    bit exp_rstv = 1'b1;
    int dv_cnt    = 0;
    int err_cnt   = 0;
    int stall_cnt = 0;

    always @(negedge clk) begin
        int s;
        chk("in_ready", int'(bus_s.in_ready), int'(exp_rdy));
        chk("out_valid_s", int'(bus_s.out_valid), int'(exp_s.size() != 0));
        chk("out_valid_w", int'(bus_w.out_valid), int'(exp_w.size() != 0));
        if (bus_s.out_valid && exp_s.size() != 0) begin
            chk("out_q_s", int'($signed(bus_s.out_q)), exp_s[0]);
            chk("out_last_s", int'(bus_s.out_last), int'(exp_s.size() == 1));
        end
        if (bus_w.out_valid && exp_w.size() != 0) begin
            chk("out_q_w", int'($signed(bus_w.out_q)), exp_w[0]);
            chk("out_last_w", int'(bus_w.out_last), int'(exp_w.size() == 1));
        end
        chk("dec_s", int'(bus_s.dec), int'(exp_dec));
        chk("dec_w", int'(bus_w.dec), int'(exp_dec));
        chk("dec_valid", int'(bus_s.dec_valid), int'(exp_dv));
        chk("err", int'(bus_s.err), int'(exp_err));
        if (exp_rstv) begin
            chk("rst_out_q", int'(bus_s.out_q), 0);
            chk("rst_out_last", int'(bus_s.out_last), 0);
        end
        dv_cnt  += int'(bus_s.dec_valid);
        err_cnt += int'(bus_s.err);

        if (rst) begin
            exp_s.delete();
            exp_w.delete();
            m_r.delete();
            m_col    = 1'b0;
            exp_dec  = 1'b0;
            exp_dv   = 1'b0;
            exp_err  = 1'b0;
            exp_rdy  = 1'b0;
            exp_rstv = 1'b1;
        end else begin
            exp_dv   = 1'b0;
            exp_err  = 1'b0;
            exp_rstv = 1'b0;
            if (bus_s.out_valid && !bus_s.out_ready) stall_cnt++;
            if (bus_s.out_valid && bus_s.out_ready) begin
                seen_s.push_back(int'($signed(bus_s.out_q)));
                if (exp_s.size() != 0) void'(exp_s.pop_front());
            end
            if (bus_w.out_valid && bus_w.out_ready) begin
                seen_w.push_back(int'($signed(bus_w.out_q)));
                if (exp_w.size() != 0) void'(exp_w.pop_front());
            end
            if (bus_s.in_valid && bus_s.in_ready) begin
                if (bus_s.in_first) begin
                    if (m_col) exp_err = 1'b1;
                    m_col = 1'b0;
                    if (bus_s.in_deg == 0) begin
                        exp_dec = bus_s.in_data[7];
                        exp_dv  = 1'b1;
                    end else if (int'(bus_s.in_deg) > 12) begin
                        exp_err = 1'b1;
                    end else begin
                        m_col = 1'b1;
                        m_l   = int'($signed(bus_s.in_data));
                        m_deg = int'(bus_s.in_deg);
                        m_r.delete();
                    end
                end else if (!m_col) begin
                    exp_err = 1'b1;
                end else begin
                    m_r.push_back(int'($signed(bus_s.in_data)));
                    if (m_r.size() == m_deg) begin
                        s = m_l;
                        foreach (m_r[i]) s += m_r[i];
                        exp_dec = (s < 0);
                        exp_dv  = 1'b1;
                        foreach (m_r[i]) begin
                            exp_s.push_back(mq(s, m_r[i], 1'b1));
                            exp_w.push_back(mq(s, m_r[i], 1'b0));
                        end
                        m_col = 1'b0;
                    end
                end
            end
            exp_rdy = (exp_s.size() == 0);
        end
    end

    int rmode = 0;
    int pidx  = 0;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        bus_s.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus_s.out_ready = 1'b1;
                1: bus_s.out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (bus_s.out_valid && pidx < 6) begin
                        bus_s.out_ready = pat[pidx];
                        pidx++;
                    end else begin
                        bus_s.out_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input bit first, input int d, input int dg);
        bit taken = 1'b0;
        int n = 0;
        bus_s.in_valid = 1'b1;
        bus_s.in_first = first;
        bus_s.in_data  = 8'(d);
        bus_s.in_deg   = 4'(dg);
        while (!taken && n < 400) begin
            @(negedge clk);
            taken = bus_s.in_ready;
            tick();
            n++;
        end
        bus_s.in_valid = 1'b0;
        if (!taken) chk("beat_timeout", 0, 1);
    endtask

    int fr_r[16];

    task automatic send_frame(input int l, input int dg, input int nmsg);
        send_beat(1'b1, l, dg);
        for (int i = 0; i < nmsg; i++) send_beat(1'b0, fr_r[i], 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_s.size() != 0 || bus_s.out_valid) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("drain_timeout", 0, 1);
        tick();
    endtask

    int expv[16];

    task automatic check_seen(input string nm, input int n);
        chk({nm, "_count"}, seen_s.size(), n);
        for (int i = 0; i < n && i < seen_s.size(); i++) chk(nm, seen_s[i], expv[i]);
        seen_s.delete();
        seen_w.delete();
    endtask

    task automatic load_t1();
        fr_r[0] = 10; fr_r[1] = -3; fr_r[2] = 7;
        expv[0] = 9;  expv[1] = 22; expv[2] = 12;
    endtask

    initial begin
        int dv0, er0, l, dg, k;
        bus_s.in_valid = 1'b0;
        bus_s.in_first = 1'b0;
        bus_s.in_data  = '0;
        bus_s.in_deg   = '0;

        chk("model_q_basic", mq(19, 10, 1'b1), 9);
        chk("model_q_sat", mq(1651, 127, 1'b1), 127);
        chk("model_q_wide", mq(1651, 127, 1'b0), 1524);
        chk("model_q_neg_clamp", mq(-1664, -128, 1'b1), -127);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_reset_in_ready", int'(bus_s.in_ready), 1);

        dv0 = dv_cnt;
        load_t1();
        send_frame(5, 3, 3);
        wait_idle();
        check_seen("t1_q", 3);
        chk("t1_dec", int'(bus_s.dec), 0);
        chk("t1_dv_pulses", dv_cnt - dv0, 1);

        fr_r[0] = 4; fr_r[1] = 4;
        expv[0] = -16; expv[1] = -16;
        send_frame(-20, 2, 2);
        wait_idle();
        check_seen("t2_q", 2);
        chk("t2_dec", int'(bus_s.dec), 1);

        for (int i = 0; i < 12; i++) begin
            fr_r[i] = 127;
            expv[i] = 127;
        end
        send_frame(127, 12, 12);
        wait_idle();
        chk("t3_wide_count", seen_w.size(), 12);
        for (int i = 0; i < seen_w.size(); i++) chk("t3_wide_q", seen_w[i], 1524);
        check_seen("t3_sat_q", 12);

        stall_cnt = 0;
        pidx  = 0;
        rmode = 2;
        load_t1();
        send_frame(5, 3, 3);
        wait_idle();
        rmode = 0;
        check_seen("t4_q", 3);
        chk("t4_stalls", stall_cnt, 3);

        dv0 = dv_cnt;
        send_beat(1'b1, -3, 0);
        wait_idle();
        chk("t5_deg0_dv", dv_cnt - dv0, 1);
        chk("t5_deg0_dec", int'(bus_s.dec), 1);
        chk("t5_deg0_noout", seen_s.size(), 0);

        er0 = err_cnt;
        dv0 = dv_cnt;
        send_beat(1'b1, 5, 13);
        wait_idle();
        chk("t5_deg13_err", err_cnt - er0, 1);
        chk("t5_deg13_nodv", dv_cnt - dv0, 0);
        chk("t5_deg13_noout", seen_s.size(), 0);

        er0 = err_cnt;
        send_beat(1'b1, 5, 3);
        send_beat(1'b0, 10, 0);
        load_t1();
        send_frame(5, 3, 3);
        wait_idle();
        chk("t5_restart_err", err_cnt - er0, 1);
        check_seen("t5_restart_q", 3);

        fr_r[0] = -50;
        send_frame(-20, 1, 1);
        wait_idle();
        seen_s.delete();
        seen_w.delete();
        send_beat(1'b1, 5, 3);
        send_beat(1'b0, 10, 0);
        send_beat(1'b0, -3, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_in_ready", int'(bus_s.in_ready), 1);
        chk("t6_out_valid", int'(bus_s.out_valid), 0);
        chk("t6_dec", int'(bus_s.dec), 0);
        load_t1();
        send_frame(5, 3, 3);
        wait_idle();
        check_seen("t6_q", 3);

        for (int f = 0; f < 150; f++) begin
            rmode = $urandom_range(0, 1);
            k = $urandom_range(0, 19);
            l = int'($urandom_range(0, 255)) - 128;
            if (k == 0) begin
                send_beat(1'b0, l, $urandom_range(0, 15));
            end else if (k == 1) begin
                send_beat(1'b1, l, $urandom_range(13, 15));
            end else if (k == 2) begin
                dg = $urandom_range(2, 12);
                send_beat(1'b1, l, dg);
                for (int i = 0; i < dg - 1; i++) send_beat(1'b0, int'($urandom_range(0, 255)), 0);
            end else if (k == 3) begin
                for (int i = 0; i < 12; i++) fr_r[i] = -128;
                send_frame(-128, 12, 12);
            end else begin
                dg = $urandom_range(0, 12);
                for (int i = 0; i < dg; i++) fr_r[i] = int'($urandom_range(0, 255)) - 128;
                send_frame(l, dg, dg);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
        send_beat(1'b1, 0, 0);
        wait_idle();
        rmode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
